// File: rtl/sprite_line_buffer.sv
// sprite_line_buffer: double-buffered 1024x16 sprite line store with display read-clear,
// background sweep of the unread tail, and post-reset bank initialisation.
module sprite_line_buffer #(
    parameter int CLR_START = 640
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_render_start,
    input  logic        sprites_enabled,
    input  logic [9:0]  linebuf_rdidx,
    output logic [15:0] linebuf_rddata,
    input  logic [9:0]  linebuf_wridx,
    input  logic [15:0] linebuf_wrdata,
    input  logic        linebuf_wren,
    input  logic [9:0]  disp_rdidx,
    input  logic        disp_rden,
    output logic [15:0] disp_rddata,
    output logic        init_busy,
    output logic        clr_overrun
);
    typedef enum logic [1:0] {INIT, SWEEP, IDLE} state_t;

    state_t      state_q, state_d;
    logic        bank_q, bank_d;
    logic        clr_overrun_q, clr_overrun_d;
    logic [9:0]  clr_idx_q, clr_idx_d;
    logic [9:0]  init_cnt_q, init_cnt_d;
    logic [15:0] linebuf_rddata_q, linebuf_rddata_d;
    logic [15:0] disp_rddata_q, disp_rddata_d;

    logic [15:0] mem0 [1024];
    logic [15:0] mem1 [1024];

    logic        init, swap, rb, sweep_wr, dwe;
    logic [9:0]  dwa;
    logic        we0, we1;
    logic [9:0]  wa0, wa1;
    logic [15:0] wd0, wd1;
    logic [15:0] rd_render, rd_disp;

    // The swap is applied combinationally so swap-cycle renderer accesses hit the new bank.
    always_comb begin
        init      = state_q == INIT;
        swap      = line_render_start && !init;
        rb        = bank_q ^ swap;
        sweep_wr  = state_q == SWEEP && !swap && !disp_rden;
        dwe       = disp_rden || sweep_wr;
        dwa       = disp_rden ? disp_rdidx : clr_idx_q;
        rd_render = rb ? mem1[linebuf_rdidx] : mem0[linebuf_rdidx];
        rd_disp   = rb ? mem0[disp_rdidx] : mem1[disp_rdidx];
        we0       = init || (rb ? dwe : linebuf_wren);
        wa0       = init ? init_cnt_q : (rb ? dwa : linebuf_wridx);
        wd0       = (init || rb) ? 16'h0 : linebuf_wrdata;
        we1       = init || (rb ? linebuf_wren : dwe);
        wa1       = init ? init_cnt_q : (rb ? linebuf_wridx : dwa);
        wd1       = (init || !rb) ? 16'h0 : linebuf_wrdata;
        linebuf_rddata_d = init ? 16'h0 :
                           (linebuf_wren && linebuf_wridx == linebuf_rdidx) ? linebuf_wrdata : rd_render;
        disp_rddata_d    = (!init && disp_rden && sprites_enabled) ? rd_disp : 16'h0;
    end

    always_comb begin
        state_d       = state_q;
        bank_d        = bank_q;
        clr_overrun_d = clr_overrun_q;
        clr_idx_d     = clr_idx_q;
        init_cnt_d    = init_cnt_q;
        if (init) begin
            init_cnt_d = (&init_cnt_q) ? init_cnt_q : init_cnt_q + 10'd1;
            state_d    = (&init_cnt_q) ? IDLE : INIT;
        end else if (swap) begin
            bank_d        = ~bank_q;
            clr_idx_d     = 10'(CLR_START);
            state_d       = SWEEP;
            clr_overrun_d = clr_overrun_q || state_q == SWEEP;
        end else if (sweep_wr) begin
            clr_idx_d = (&clr_idx_q) ? clr_idx_q : clr_idx_q + 10'd1;
            state_d   = (&clr_idx_q) ? IDLE : SWEEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= INIT;
            bank_q           <= 1'b0;
            clr_overrun_q    <= 1'b0;
            clr_idx_q        <= 10'(CLR_START);
            init_cnt_q       <= 10'd0;
            linebuf_rddata_q <= 16'h0;
            disp_rddata_q    <= 16'h0;
        end else begin
            state_q          <= state_d;
            bank_q           <= bank_d;
            clr_overrun_q    <= clr_overrun_d;
            clr_idx_q        <= clr_idx_d;
            init_cnt_q       <= init_cnt_d;
            linebuf_rddata_q <= linebuf_rddata_d;
            disp_rddata_q    <= disp_rddata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we0) mem0[wa0] <= wd0;
        if (we1) mem1[wa1] <= wd1;
    end

    assign linebuf_rddata = linebuf_rddata_q;
    assign disp_rddata    = disp_rddata_q;
    assign init_busy      = state_q == INIT;
    assign clr_overrun    = clr_overrun_q;
endmodule

// File: tb/tb_sprite_line_buffer.sv
// tb_sprite_line_buffer: directed checks of init, bank swap, read-clear, sweep and overrun.
module tb_sprite_line_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line_render_start = 1'b0;
    logic        sprites_enabled = 1'b1;
    logic [9:0]  linebuf_rdidx = '0;
    logic [15:0] linebuf_rddata;
    logic [9:0]  linebuf_wridx = '0;
    logic [15:0] linebuf_wrdata = '0;
    logic        linebuf_wren = 1'b0;
    logic [9:0]  disp_rdidx = '0;
    logic        disp_rden = 1'b0;
    logic [15:0] disp_rddata;
    logic        init_busy;
    logic        clr_overrun;
    int          n_cmp = 0;
    int          n_bad = 0;

    sprite_line_buffer dut (
        .clk(clk), .rst(rst), .line_render_start(line_render_start),
        .sprites_enabled(sprites_enabled), .linebuf_rdidx(linebuf_rdidx),
        .linebuf_rddata(linebuf_rddata), .linebuf_wridx(linebuf_wridx),
        .linebuf_wrdata(linebuf_wrdata), .linebuf_wren(linebuf_wren),
        .disp_rdidx(disp_rdidx), .disp_rden(disp_rden), .disp_rddata(disp_rddata),
        .init_busy(init_busy), .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wr(input logic [9:0] idx, input logic [15:0] data);
        linebuf_wren = 1'b1; linebuf_wridx = idx; linebuf_wrdata = data;
        step();
        linebuf_wren = 1'b0;
    endtask

    task automatic swap();
        line_render_start = 1'b1;
        step();
        line_render_start = 1'b0;
    endtask

    task automatic rd_render(input string tag, input logic [9:0] idx, input logic [15:0] exp);
        linebuf_rdidx = idx;
        step();
        chk(tag, linebuf_rddata, exp);
    endtask

    task automatic rd_disp(input string tag, input logic [9:0] idx, input logic [15:0] exp);
        disp_rden = 1'b1; disp_rdidx = idx;
        step();
        disp_rden = 1'b0;
        chk(tag, disp_rddata, exp);
    endtask

    initial begin
        step(3);
        chk("rst_linebuf_rddata", linebuf_rddata, 16'h0);
        chk("rst_disp_rddata", disp_rddata, 16'h0);
        chk("rst_init_busy", {15'h0, init_busy}, 16'h1);
        chk("rst_clr_overrun", {15'h0, clr_overrun}, 16'h0);
        rst = 1'b0;
        step(1023);
        chk("init_busy_1023", {15'h0, init_busy}, 16'h1);
        step();
        chk("init_busy_1024", {15'h0, init_busy}, 16'h0);

        rd_render("post_init_render", 10'd5, 16'h0);
        rd_disp("post_init_disp", 10'd700, 16'h0);

        linebuf_rdidx = 10'd100;
        wr(10'd100, 16'h1234);
        chk("bypass", linebuf_rddata, 16'h1234);
        wr(10'd5, 16'h3A15);
        chk("stored_100", linebuf_rddata, 16'h1234);
        rd_render("stored_5", 10'd5, 16'h3A15);

        swap();
        chk("swap_cycle_read_new_bank", linebuf_rddata, 16'h0);
        rd_disp("disp_read_5", 10'd5, 16'h3A15);
        rd_disp("disp_reread_5", 10'd5, 16'h0);
        step();
        chk("disp_rden_low", disp_rddata, 16'h0);

        sprites_enabled = 1'b0;
        rd_disp("disabled_read_100", 10'd100, 16'h0);
        sprites_enabled = 1'b1;
        rd_disp("reenabled_read_100", 10'd100, 16'h0);

        wr(10'd700, 16'hFFFF);
        wr(10'd1023, 16'hBEEF);
        wr(10'd640, 16'h0640);
        wr(10'd639, 16'h0639);
        step(400);
        swap();
        step(384);
        swap();
        chk("no_overrun_exact_sweep", {15'h0, clr_overrun}, 16'h0);
        rd_render("swept_700", 10'd700, 16'h0);
        rd_render("swept_1023", 10'd1023, 16'h0);
        rd_render("swept_640", 10'd640, 16'h0);
        rd_render("unswept_639", 10'd639, 16'h0639);

        step(400);
        swap();
        step(383);
        chk("no_overrun_before", {15'h0, clr_overrun}, 16'h0);
        swap();
        chk("overrun_set", {15'h0, clr_overrun}, 16'h1);
        step(400);
        swap();
        step(400);
        swap();
        chk("overrun_sticky", {15'h0, clr_overrun}, 16'h1);
        chk("init_busy_stays_low", {15'h0, init_busy}, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
